// File: rtl/veh_sensor_cond_if.sv
// Signal bundle between the farm-road loop conditioner and its environment.
// The slave side is the conditioner itself. The master side is whatever
// drives the loop, the green acknowledge and the count clear.
interface veh_sensor_cond_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             sensor_raw;
  logic             farm_green;
  logic             cnt_clr;
  logic             veh_req;
  logic             veh_present;
  logic             veh_arrive;
  logic [CNT_W-1:0] veh_count;

  // Environment side: drives the loop, the acknowledge and the control inputs.
  modport master (
    output ena,
    output sensor_raw,
    output farm_green,
    output cnt_clr,
    input  veh_req,
    input  veh_present,
    input  veh_arrive,
    input  veh_count
  );

  // Conditioner side.
  modport slave (
    input  ena,
    input  sensor_raw,
    input  farm_green,
    input  cnt_clr,
    output veh_req,
    output veh_present,
    output veh_arrive,
    output veh_count
  );
endinterface

// File: rtl/veh_sensor_cond.sv
// Farm-road vehicle-loop conditioner. It synchronises and debounces the raw
// loop signal. Each debounced arrival is held as a request until the
// controller grants farm green. The request is raised again if a vehicle is
// still waiting when green ends. A saturating arrival counter is kept for
// telemetry.
module veh_sensor_cond #(
  parameter int SYNC_STAGES     = 2,   // 2..4
  parameter int DEBOUNCE_CYCLES = 8,   // 2..255
  parameter int CNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  veh_sensor_cond_if.slave   bus
);

  localparam logic [7:0]       DEB_MAX = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // State registers
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [7:0]             dcnt_q, dcnt_d;
  logic                   present_q, present_d;
  logic                   arrive_q, arrive_d;
  logic                   req_q, req_d;
  logic                   fg_dly_q, fg_dly_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Combinational helpers
  logic sync_s;
  logic rise;     // veh_present goes 0->1 at this edge

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Shift the raw loop into the synchroniser. This runs even when the block is disabled.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.sensor_raw};
  end

  // Debounce, arrival detection, request latch and counter next-state logic.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    dcnt_d    = dcnt_q;
    present_d = present_q;
    rise      = 1'b0;
    req_d     = req_q;
    fg_dly_d  = fg_dly_q;
    cnt_d     = cnt_q;

    if (bus.ena) begin
      // Debounce: any agreeing sample restarts the run.
      if (sync_s == present_q) begin
        dcnt_d = 8'd0;
      end else if (dcnt_q == DEB_MAX) begin
        present_d = sync_s;
        dcnt_d    = 8'd0;
        rise      = sync_s;
      end else begin
        dcnt_d = dcnt_q + 8'd1;
      end

      fg_dly_d = bus.farm_green;

      // Request priority: acknowledge, then re-request at the end of green, then a new arrival.
      if (bus.farm_green) begin
        req_d = 1'b0;
      end else if (fg_dly_q && present_q) begin
        req_d = 1'b1;
      end else if (rise) begin
        req_d = 1'b1;
      end

      // Count arrivals. Clear wins over an increment in the same cycle, and the count never wraps.
      if (bus.cnt_clr) begin
        cnt_d = '0;
      end else if (rise && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // The arrival pulse is forced low while the block is disabled, because rise is only set when ena=1.
    arrive_d = rise;
  end

  // Register all state. Reset clears every flop so that no debounce or request survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      dcnt_q    <= 8'd0;
      present_q <= 1'b0;
      arrive_q  <= 1'b0;
      req_q     <= 1'b0;
      fg_dly_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      // NOTE: sequential state is written only with non-blocking assignments, so every flop samples pre-edge values.
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      present_q <= present_d;
      arrive_q  <= arrive_d;
      req_q     <= req_d;
      fg_dly_q  <= fg_dly_d;
      cnt_q     <= cnt_d;
    end
  end

  // Every output comes straight from a flop, so none of them can glitch.
  assign bus.veh_req     = req_q;
  assign bus.veh_present = present_q;
  assign bus.veh_arrive  = arrive_q;
  assign bus.veh_count   = cnt_q;

endmodule

// File: tb/tb_veh_sensor_cond.sv
// Directed self-checking bench for veh_sensor_cond with default parameters.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same point.
module tb_veh_sensor_cond;

  logic clk;
  logic rst_n;
  int   total_cnt;
  int   pass_cnt;

  veh_sensor_cond_if #(.CNT_W(8)) bus ();

  veh_sensor_cond #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive sensor high and hold it for 10 edges (debounced rise), then low for 10 edges.
  task automatic full_arrival();
    bus.sensor_raw = 1'b1;
    tick(10);
    bus.sensor_raw = 1'b0;
    tick(10);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.ena        = 1'b1;
    bus.sensor_raw = 1'b0;
    bus.farm_green = 1'b0;
    bus.cnt_clr    = 1'b0;
    tick(2);
    total_cnt++;
    if (bus.veh_present !== 1'b0) $display("FAIL reset_present got=%b exp=0", bus.veh_present);
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.veh_req);
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_arrive !== 1'b0) $display("FAIL reset_arrive got=%b exp=0", bus.veh_arrive);
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd0) $display("FAIL reset_count got=%0d exp=0", bus.veh_count);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(2);
  endtask

  // Sensor goes high (first sampled at edge k) and rises at edge k+9.
  task automatic test_clean_arrival();
    bus.sensor_raw = 1'b1;
    tick(9);
    total_cnt++;
    if (bus.veh_present !== 1'b0) $display("FAIL clean_early_present got=%b exp=0", bus.veh_present);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_arrive} !== 3'b111)
      $display("FAIL clean_rise pres/req/arr got=%b exp=111", {bus.veh_present, bus.veh_req, bus.veh_arrive});
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd1) $display("FAIL clean_count got=%0d exp=1", bus.veh_count);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if (bus.veh_arrive !== 1'b0) $display("FAIL clean_pulse_width got=%b exp=0", bus.veh_arrive);
    else pass_cnt++;
    // The vehicle leaves before service: the request must stay high, and no falling pulse may appear.
    bus.sensor_raw = 1'b0;
    tick(10);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_arrive} !== 3'b010)
      $display("FAIL clean_leave pres/req/arr got=%b exp=010", {bus.veh_present, bus.veh_req, bus.veh_arrive});
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd1) $display("FAIL clean_leave_count got=%0d exp=1", bus.veh_count);
    else pass_cnt++;
    bus.farm_green = 1'b1;
    tick(1);
    total_cnt++;
    if (bus.veh_req !== 1'b0) $display("FAIL clean_ack got=%b exp=0", bus.veh_req);
    else pass_cnt++;
    bus.farm_green = 1'b0;
    tick(2);
    total_cnt++;
    if (bus.veh_req !== 1'b0) $display("FAIL clean_no_rereq got=%b exp=0", bus.veh_req);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    total_cnt++;
    if (bus.veh_count !== 8'd0) $display("FAIL bounce_clear got=%0d exp=0", bus.veh_count);
    else pass_cnt++;
    bus.sensor_raw = 1'b1; tick(5);
    bus.sensor_raw = 1'b0; tick(1);
    bus.sensor_raw = 1'b1; tick(5);
    bus.sensor_raw = 1'b0; tick(6);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_arrive} !== 3'b000)
      $display("FAIL bounce_reject pres/req/arr got=%b exp=000", {bus.veh_present, bus.veh_req, bus.veh_arrive});
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd0) $display("FAIL bounce_count got=%0d exp=0", bus.veh_count);
    else pass_cnt++;
    bus.sensor_raw = 1'b1;
    tick(10);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_count} !== {2'b11, 8'd1})
      $display("FAIL bounce_hold pres/req/cnt got=%b/%b/%0d exp=1/1/1", bus.veh_present, bus.veh_req, bus.veh_count);
    else pass_cnt++;
  endtask

  // Entry: present=1, req=1, sensor high.
  task automatic test_ack_rerequest();
    bus.farm_green = 1'b1;
    tick(1);
    total_cnt++;
    if (bus.veh_req !== 1'b0) $display("FAIL ack_drop got=%b exp=0", bus.veh_req);
    else pass_cnt++;
    bus.farm_green = 1'b0;
    tick(1);
    total_cnt++;
    if (bus.veh_req !== 1'b1) $display("FAIL ack_rereq got=%b exp=1", bus.veh_req);
    else pass_cnt++;
    bus.farm_green = 1'b1;
    tick(1);
    bus.sensor_raw = 1'b0;
    tick(10);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req} !== 2'b00)
      $display("FAIL ack_gone pres/req got=%b exp=00", {bus.veh_present, bus.veh_req});
    else pass_cnt++;
    bus.farm_green = 1'b0;
    tick(2);
    total_cnt++;
    if (bus.veh_req !== 1'b0) $display("FAIL ack_empty_no_rereq got=%b exp=0", bus.veh_req);
    else pass_cnt++;
  endtask

  // Entry: present=0, req=0, count=1.
  task automatic test_simultaneous_ack();
    bus.farm_green = 1'b1;
    bus.sensor_raw = 1'b1;
    tick(10);
    total_cnt++;
    if ({bus.veh_present, bus.veh_arrive, bus.veh_req} !== 3'b110)
      $display("FAIL simul pres/arr/req got=%b exp=110", {bus.veh_present, bus.veh_arrive, bus.veh_req});
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd2) $display("FAIL simul_count got=%0d exp=2", bus.veh_count);
    else pass_cnt++;
    tick(1);
    bus.farm_green = 1'b0;
    tick(1);
    total_cnt++;
    if (bus.veh_req !== 1'b1) $display("FAIL simul_green_end_rereq got=%b exp=1", bus.veh_req);
    else pass_cnt++;
    bus.farm_green = 1'b1;
    tick(1);
    bus.sensor_raw = 1'b0;
    tick(10);
    bus.farm_green = 1'b0;
    tick(2);
  endtask

  task automatic test_saturation_clear();
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 255; i++) full_arrival();
    total_cnt++;
    if (bus.veh_count !== 8'd255) $display("FAIL sat_255 got=%0d exp=255", bus.veh_count);
    else pass_cnt++;
    bus.sensor_raw = 1'b1;
    tick(10);
    total_cnt++;
    if ({bus.veh_arrive, bus.veh_count} !== {1'b1, 8'd255})
      $display("FAIL sat_hold arr/cnt got=%b/%0d exp=1/255", bus.veh_arrive, bus.veh_count);
    else pass_cnt++;
    bus.sensor_raw = 1'b0;
    tick(10);
    // Clear on the same edge as an arrival.
    bus.sensor_raw = 1'b1;
    tick(9);
    bus.cnt_clr = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    total_cnt++;
    if ({bus.veh_present, bus.veh_arrive, bus.veh_count} !== {2'b11, 8'd0})
      $display("FAIL clr_vs_inc pres/arr/cnt got=%b/%b/%0d exp=1/1/0", bus.veh_present, bus.veh_arrive, bus.veh_count);
    else pass_cnt++;
    bus.sensor_raw = 1'b0;
    tick(10);
    full_arrival();
    bus.farm_green = 1'b1;
    tick(1);
    bus.farm_green = 1'b0;
    tick(2);
  endtask

  // Entry: present=0, req=0, count=1.
  task automatic test_enable();
    bus.sensor_raw = 1'b1;
    tick(5);            // dcnt reaches 3
    bus.ena     = 1'b0;
    bus.cnt_clr = 1'b1;
    tick(20);
    total_cnt++;
    if ({bus.veh_present, bus.veh_arrive, bus.veh_req} !== 3'b000)
      $display("FAIL ena_frozen pres/arr/req got=%b exp=000", {bus.veh_present, bus.veh_arrive, bus.veh_req});
    else pass_cnt++;
    total_cnt++;
    if (bus.veh_count !== 8'd1) $display("FAIL ena_clr_ignored got=%0d exp=1", bus.veh_count);
    else pass_cnt++;
    bus.ena     = 1'b1;
    bus.cnt_clr = 1'b0;
    tick(4);            // dcnt goes 4,5,6,7
    total_cnt++;
    if (bus.veh_present !== 1'b0) $display("FAIL ena_resume_early got=%b exp=0", bus.veh_present);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({bus.veh_present, bus.veh_arrive, bus.veh_req, bus.veh_count} !== {3'b111, 8'd2})
      $display("FAIL ena_resume pres/arr/req/cnt got=%b/%b/%b/%0d exp=1/1/1/2",
               bus.veh_present, bus.veh_arrive, bus.veh_req, bus.veh_count);
    else pass_cnt++;
  endtask

  // Entry: present=1, req=1, count=2, sensor high.
  task automatic test_async_reset();
    tick(1);
    rst_n = 1'b0;
    #2;                 // still before the next rising edge
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_arrive, bus.veh_count} !== {3'b000, 8'd0})
      $display("FAIL async_reset pres/req/arr/cnt got=%b/%b/%b/%0d exp=0/0/0/0",
               bus.veh_present, bus.veh_req, bus.veh_arrive, bus.veh_count);
    else pass_cnt++;
    rst_n = 1'b1;
    tick(9);
    total_cnt++;
    if (bus.veh_present !== 1'b0) $display("FAIL post_reset_early got=%b exp=0", bus.veh_present);
    else pass_cnt++;
    tick(1);
    total_cnt++;
    if ({bus.veh_present, bus.veh_req, bus.veh_count} !== {2'b11, 8'd1})
      $display("FAIL post_reset_arrival pres/req/cnt got=%b/%b/%0d exp=1/1/1", bus.veh_present, bus.veh_req, bus.veh_count);
    else pass_cnt++;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    test_reset();
    test_clean_arrival();
    test_bounce();
    test_ack_rerequest();
    test_simultaneous_ack();
    test_saturation_clear();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
